// File: rtl/adder_error_monitor_if.sv
// Operand/sum handshake bundle between the adder under test and its monitor.
// The master drives a pair plus the approximate sum; the slave signals readiness.
interface adder_error_monitor_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   approx_s;

    modport master (
        output in_valid,
        output a,
        output b,
        output approx_s,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  approx_s,
        output in_ready
    );
endinterface

// File: rtl/adder_error_monitor.sv
// Error statistics monitor for an approximate adder: counts samples and
// mismatches and tracks max and accumulated error distance over a run.
module adder_error_monitor #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     n_samples,
    adder_error_monitor_if.slave bus,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sample_count,
    output logic [CNT_W-1:0]     err_count,
    output logic [WIDTH:0]       max_ed,
    output logic [ACC_W-1:0]     sum_ed
);

    localparam int SW = ((ACC_W > WIDTH + 1) ? ACC_W : WIDTH + 1) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t stateNext;

    logic [CNT_W-1:0] nSamplesQ;
    logic             s1Valid;
    logic [WIDTH-1:0] aQ;
    logic [WIDTH-1:0] bQ;
    logic [WIDTH:0]   approxQ;

    logic             accept;
    logic             startRun;
    logic             lastAccept;
    logic [WIDTH:0]   exact;
    logic [WIDTH:0]   ed;
    logic [SW-1:0]    sumWide;
    logic [ACC_W-1:0] sumSat;
    logic [CNT_W-1:0] errInc;

    assign bus.in_ready = (state == RUN);
    assign accept       = bus.in_valid && bus.in_ready;
    assign startRun     = (state == IDLE) && start;
    assign lastAccept   = accept &&
                          ((sample_count + CNT_W'(1)) == nSamplesQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    stateNext = (n_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (lastAccept) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (!s1Valid) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Stage 1: capture the accepted pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid <= 1'b0;
            aQ      <= '0;
            bQ      <= '0;
            approxQ <= '0;
        end else begin
            s1Valid <= accept;
            if (accept) begin
                aQ      <= bus.a;
                bQ      <= bus.b;
                approxQ <= bus.approx_s;
            end
        end
    end

    // Stage 2: exact sum keeps the carry, distance is unsigned
    always_comb begin
        exact   = {1'b0, aQ} + {1'b0, bQ};
        ed      = (exact >= approxQ) ? (exact - approxQ) : (approxQ - exact);
        sumWide = SW'(sum_ed) + SW'(ed);
        sumSat  = (sumWide > SW'({ACC_W{1'b1}})) ? '1 : sumWide[ACC_W-1:0];
        errInc  = (err_count != '1) ? (err_count + CNT_W'(1)) : err_count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nSamplesQ    <= '0;
            sample_count <= '0;
            err_count    <= '0;
            max_ed       <= '0;
            sum_ed       <= '0;
        end else if (startRun) begin
            nSamplesQ    <= n_samples;
            sample_count <= '0;
            err_count    <= '0;
            max_ed       <= '0;
            sum_ed       <= '0;
        end else begin
            if (accept) begin
                sample_count <= sample_count + CNT_W'(1);
            end
            if (s1Valid) begin
                if (ed != '0) begin
                    err_count <= errInc;
                end
                if (ed > max_ed) begin
                    max_ed <= ed;
                end
                sum_ed <= sumSat;
            end
        end
    end

    // done trails the DONE state by one cycle so it is a clean flop output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (stateNext == RUN) || (stateNext == DRAIN);
            done <= (state == DONE);
        end
    end

endmodule
